// File: rtl/demixer_iq.sv
// rtl/demixer_iq.sv - IQ demixer: real sample times ternary LO, integrate-and-dump per frame
//
// Purpose:
//   Multiplies each accepted real sample by in-phase and quadrature LO values
//   (-1/0/+1). It sums the products over 2**DECIM_LOG2 accepted samples. It
//   then presents the floor-scaled, 15-bit saturated frame averages.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   clr          in   synchronous frame restart (drops the sample on that edge)
//   mixin_valid  in   qualifies mixin
//   mixin[14:0]  in   real sample, two's complement
//   LO_i[1:0]    in   in-phase LO: 1x = -1, 01 = +1, 00 = 0
//   LO_q[1:0]    in   quadrature LO, same encoding
//   out_ready    in   downstream consumes the held result
//   out_valid    out  i_o/q_o hold an unconsumed result
//   i_o[14:0]    out  in-phase frame result
//   q_o[14:0]    out  quadrature frame result
//   overrun      out  sticky: an unconsumed result was overwritten

module demixer_iq #(
  parameter int DECIM_LOG2 = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  input  logic        mixin_valid,
  input  logic [14:0] mixin,
  input  logic [1:0]  LO_i,
  input  logic [1:0]  LO_q,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [14:0] i_o,
  output logic [14:0] q_o,
  output logic        overrun
);

  // 16-bit terms summed over 2**DECIM_LOG2 samples cannot exceed this width.
  localparam int AW = 16 + DECIM_LOG2;
  localparam logic signed [AW-1:0] SAT_MAX = AW'(16383);
  localparam logic signed [AW-1:0] SAT_MIN = AW'(-16384);

  logic signed [AW-1:0]     r_acc_i;
  logic signed [AW-1:0]     r_acc_q;
  logic [DECIM_LOG2-1:0]    r_cnt;

  logic                     w_accept;
  logic                     w_dump;
  logic signed [15:0]       w_mix_ext;
  logic signed [15:0]       w_term_i;
  logic signed [15:0]       w_term_q;
  logic signed [AW-1:0]     w_sum_i;
  logic signed [AW-1:0]     w_sum_q;
  logic signed [AW-1:0]     w_shr_i;
  logic signed [AW-1:0]     w_shr_q;

  // The 16-bit width lets -(-16384) land exactly on +16384.
  function automatic logic signed [15:0] f_lo_mul(input logic signed [15:0] s,
                                                  input logic [1:0] lo);
    if (lo[1])      return -s;
    else if (lo[0]) return s;
    else            return '0;
  endfunction

  function automatic logic [14:0] f_sat(input logic signed [AW-1:0] v);
    if (v > SAT_MAX)      return 15'h3FFF;
    else if (v < SAT_MIN) return 15'h4000;
    else                  return v[14:0];
  endfunction

  assign w_accept  = mixin_valid && !clr;
  assign w_dump    = w_accept && (r_cnt == {DECIM_LOG2{1'b1}});
  assign w_mix_ext = {mixin[14], mixin};
  assign w_term_i  = f_lo_mul(w_mix_ext, LO_i);
  assign w_term_q  = f_lo_mul(w_mix_ext, LO_q);
  assign w_sum_i   = r_acc_i + {{DECIM_LOG2{w_term_i[15]}}, w_term_i};
  assign w_sum_q   = r_acc_q + {{DECIM_LOG2{w_term_q[15]}}, w_term_q};
  // An arithmetic shift of a two's complement value rounds toward minus infinity.
  assign w_shr_i   = w_sum_i >>> DECIM_LOG2;
  assign w_shr_q   = w_sum_q >>> DECIM_LOG2;

  // Accumulators and sample counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc_i <= '0;
      r_acc_q <= '0;
      r_cnt   <= '0;
    end else if (clr || w_dump) begin
      r_acc_i <= '0;
      r_acc_q <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_acc_i <= w_sum_i;
      r_acc_q <= w_sum_q;
      r_cnt   <= r_cnt + DECIM_LOG2'(1);
    end
  end

  // Result holding register. clr never touches it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      i_o       <= '0;
      q_o       <= '0;
      overrun   <= 1'b0;
    end else if (w_dump) begin
      i_o       <= f_sat(w_shr_i);
      q_o       <= f_sat(w_shr_q);
      out_valid <= 1'b1;
      if (out_valid && !out_ready) overrun <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_demixer_iq.sv
// tb/tb_demixer_iq.sv - randomized and directed self-checking bench for demixer_iq

module tb_demixer_iq;

  localparam int DL    = 3;
  localparam int DECIM = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clr = 1'b0;
  logic        mixin_valid = 1'b0;
  logic [14:0] mixin = '0;
  logic [1:0]  LO_i = '0;
  logic [1:0]  LO_q = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [14:0] i_o;
  logic [14:0] q_o;
  logic        overrun;

  int total = 0;
  int bad   = 0;
  string scn = "init";

  // Reference state: frame sample count, running integer sums, held result.
  int m_cnt, m_si, m_sq, m_i, m_q;
  int m_valid, m_ovr;

  demixer_iq #(.DECIM_LOG2(DL)) dut (
    .clock(clock), .reset(reset), .clr(clr), .mixin_valid(mixin_valid),
    .mixin(mixin), .LO_i(LO_i), .LO_q(LO_q), .out_ready(out_ready),
    .out_valid(out_valid), .i_o(i_o), .q_o(q_o), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s/%s: got %0d want %0d", scn, tag, obs, exp);
    end
  endtask

  function automatic int lo_val(input logic [1:0] lo);
    if (lo[1]) return -1;
    if (lo[0]) return 1;
    return 0;
  endfunction

  function automatic int frame_result(input int s);
    int q;
    q = s / DECIM;
    if ((s % DECIM != 0) && (s < 0)) q = q - 1;
    if (q > 16383) q = 16383;
    if (q < -16384) q = -16384;
    return q;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_si = 0; m_sq = 0; m_i = 0; m_q = 0; m_valid = 0; m_ovr = 0;
  endtask

  task automatic check_outputs();
    check("out_valid", int'(out_valid), m_valid);
    check("i_o", int'($signed(i_o)), m_i);
    check("q_o", int'($signed(q_o)), m_q);
    check("overrun", int'(overrun), m_ovr);
  endtask

  task automatic step(input bit v, input int mix, input logic [1:0] li,
                      input logic [1:0] lq, input bit c, input bit rdy);
    bit dump;
    mixin_valid = v; mixin = 15'(mix); LO_i = li; LO_q = lq; clr = c; out_ready = rdy;
    @(posedge clock);
    dump = 0;
    if (c) begin
      m_cnt = 0; m_si = 0; m_sq = 0;
    end else if (v) begin
      m_si += mix * lo_val(li);
      m_sq += mix * lo_val(lq);
      m_cnt++;
      if (m_cnt == DECIM) begin
        dump = 1;
        if (m_valid != 0 && !rdy) m_ovr = 1;
        m_i = frame_result(m_si);
        m_q = frame_result(m_sq);
        m_valid = 1;
        m_cnt = 0; m_si = 0; m_sq = 0;
      end
    end
    if (!dump && m_valid != 0 && rdy) m_valid = 0;
    #1;
    check_outputs();
  endtask

  task automatic drain();
    step(0, 0, 2'b00, 2'b00, 0, 1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    scn = "reset";
    check_outputs();
    #3 reset = 1'b1;

    scn = "dc_i";
    for (int k = 0; k < 8; k++) step(1, 1000, 2'b01, 2'b00, 0, 1);
    check("lit_i", int'($signed(i_o)), 1000);
    check("lit_q", int'($signed(q_o)), 0);
    check("lit_valid", int'(out_valid), 1);
    drain();
    check("lit_valid_drop", int'(out_valid), 0);

    scn = "saturate";
    for (int k = 0; k < 8; k++) step(1, -16384, 2'b10, 2'b01, 0, 1);
    check("lit_i", int'($signed(i_o)), 16383);
    check("lit_q", int'($signed(q_o)), -16384);
    drain();

    scn = "alt_lo";
    for (int k = 0; k < 8; k++) step(1, 500, (k % 2 == 0) ? 2'b01 : 2'b10, 2'b01, 0, 1);
    check("lit_i", int'($signed(i_o)), 0);
    check("lit_q", int'($signed(q_o)), 500);
    drain();

    scn = "floor";
    step(1, -1, 2'b01, 2'b00, 0, 1);
    for (int k = 0; k < 7; k++) step(1, -1, 2'b00, 2'b00, 0, 1);
    check("lit_i", int'($signed(i_o)), -1);
    drain();

    scn = "overrun";
    for (int k = 0; k < 8; k++) step(1, 100, 2'b01, 2'b00, 0, 0);
    for (int k = 0; k < 8; k++) step(1, 200, 2'b01, 2'b00, 0, 0);
    check("lit_i", int'($signed(i_o)), 200);
    check("lit_ovr", int'(overrun), 1);
    check("lit_valid", int'(out_valid), 1);
    drain();
    check("lit_ovr_sticky", int'(overrun), 1);

    scn = "mid_reset";
    for (int k = 0; k < 5; k++) step(1, 300, 2'b01, 2'b00, 0, 1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clock);
    #1;
    check_outputs();
    #3 reset = 1'b1;
    for (int k = 0; k < 8; k++) step(1, 300, 2'b01, 2'b00, 0, 1);
    check("lit_i", int'($signed(i_o)), 300);
    drain();

    scn = "clr";
    for (int k = 0; k < 3; k++) step(1, 300, 2'b01, 2'b00, 0, 1);
    step(1, 5000, 2'b01, 2'b01, 1, 1);
    for (int k = 0; k < 7; k++) step(1, 300, 2'b01, 2'b00, 0, 1);
    check("lit_valid_early", int'(out_valid), 0);
    step(1, 300, 2'b01, 2'b00, 0, 1);
    check("lit_i", int'($signed(i_o)), 300);
    drain();

    scn = "random";
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0,
           int'($urandom_range(0, 32767)) - 16384,
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
